// File: rtl/keypad_scan_bcd_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, special key codes,
// and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Index of the low bit in a one-cold nibble.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (col == 2'd3) begin
      code = 4'hA + {2'b00, row};
    end else if (row == 2'd3) begin
      code = (col == 2'd0) ? KEY_STAR : (col == 2'd1) ? 4'h0 : KEY_HASH;
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_bcd_if.sv
// Keypad matrix lines plus key-event and BCD entry outputs of the scanner.
interface keypad_scan_bcd_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;

  modport master (
    input  col_in,
    output row_out, key_valid, key_code, digits, digit_cnt
  );

  modport slave (
    output col_in,
    input  row_out, key_valid, key_code, digits, digit_cnt
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick is high for one clk every CLK_DIV clk.
module scan_tick_gen #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/keypad_scan_bcd.sv
// 4x4 keypad scanner with debounce and a 4-digit BCD entry buffer.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_bcd
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_TICKS   = 250
) (
  input logic              clk,
  input logic              rst,
  keypad_scan_bcd_if.master kp
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_TICKS);

  logic            tick;
  logic [3:0]      col_meta_q, col_s;
  state_e          state_q, state_d;
  logic [3:0]      row_q, row_d, cap_q, cap_d;
  logic [CntW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic            emit, single_low;
  logic [3:0]      emit_code, row_rot;
  logic            key_valid_q;
  logic [3:0]      key_code_q, key_code_d;
  logic [15:0]     digits_q, digits_d;
  logic [2:0]      dcnt_q, dcnt_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_TICKS);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign single_low = ($countones(~col_s) == 1);
  assign row_rot    = {row_q[2:0], row_q[3]};
  // In SCAN the accepting pattern is the live one (only reachable with DEBOUNCE_TICKS == 1).
  assign emit_code  = key_map(low_idx(row_q), low_idx((state_q == StScan) ? col_s : cap_q));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (single_low) begin
            cap_d = col_s;
            cnt_d = CntW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              emit    = 1'b1;
              cnt_d   = '0;
              rel_d   = '0;
              state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              state_d = StDebounce;
            end
          end else begin
            row_d = row_rot;
          end
        end
        StDebounce: begin
          if (col_s == cap_q) begin
            if (cnt_q + 1'b1 == DebMax) begin
              emit    = 1'b1;
              cnt_d   = '0;
              rel_d   = '0;
              state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = StScan;
            row_d   = row_rot;
          end
        end
        StHeld: begin
          if (col_s == 4'hF) begin
            if (rel_q + 1'b1 == DebMax) begin
              rel_d   = '0;
              state_d = StScan;
            end else begin
              rel_d = rel_q + 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = '0;
`endif
          end else begin
            rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (col_s == cap_q) begin
              if (rep_q + 1'b1 == RepMax) begin
                emit  = 1'b1;
                rep_d = '0;
              end else begin
                rep_d = rep_q + 1'b1;
              end
            end
`endif
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_comb begin
    key_code_d = key_code_q;
    digits_d   = digits_q;
    dcnt_d     = dcnt_q;
    if (emit) begin
      key_code_d = emit_code;
      if (emit_code <= 4'd9) begin
        digits_d = {digits_q[11:0], emit_code};
        if (dcnt_q != 3'd4) dcnt_d = dcnt_q + 3'd1;
      end else if (emit_code == KEY_BKSP) begin
        if (dcnt_q != 3'd0) begin
          digits_d = {4'h0, digits_q[15:4]};
          dcnt_d   = dcnt_q - 3'd1;
        end
      end else if (emit_code == KEY_CLR) begin
        digits_d = '0;
        dcnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'hF;
      col_s       <= 4'hF;
      state_q     <= StScan;
      row_q       <= 4'b1110;
      cap_q       <= 4'hF;
      cnt_q       <= '0;
      rel_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digits_q    <= '0;
      dcnt_q      <= '0;
    end else begin
      col_meta_q  <= kp.col_in;
      col_s       <= col_meta_q;
      state_q     <= state_d;
      row_q       <= row_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_valid_q <= emit;
      key_code_q  <= key_code_d;
      digits_q    <= digits_d;
      dcnt_q      <= dcnt_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`endif

  assign kp.row_out   = row_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.digits    = digits_q;
  assign kp.digit_cnt = dcnt_q;
endmodule

// File: tb/tb_keypad_scan_bcd.sv
// Bench for keypad_scan_bcd: a matrix model drives the columns from the rows, and a
// digit-array model of the entry buffer predicts every event and buffer value.
module tb_keypad_scan_bcd;
  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Deb    = 3;
  localparam int unsigned Rep    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_bcd_if bus ();

  keypad_scan_bcd #(
    .CLK_DIV        (ClkDiv),
    .DEBOUNCE_TICKS (Deb),
    .REPEAT_TICKS   (Rep)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus.master)
  );

  // Key matrix: a pressed key shorts its row to its column.
  logic [15:0] pressed = '0;
  logic        ovr_en  = 1'b0;
  logic [3:0]  ovr_val = 4'hF;

  function automatic logic [3:0] kp_cols(input logic [3:0] rows, input logic [15:0] pr);
    logic [3:0] cols;
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pr[r*4+c] && !rows[r]) cols[c] = 1'b0;
    return cols;
  endfunction

  assign bus.col_in = ovr_en ? ovr_val : kp_cols(bus.row_out, pressed);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor.
  int          cyc = 0;
  int          ev_cnt = 0;
  int          ev_cyc[$];
  logic [3:0]  ev_code[$];
  logic        prev_kv = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bus.key_valid) begin
      check("kv_one_clk", {31'd0, prev_kv}, 32'd0);
      ev_cnt++;
      ev_cyc.push_back(cyc);
      ev_code.push_back(bus.key_code);
    end
    prev_kv = bus.key_valid;
  end

  // Reference model: key table and four-digit entry buffer.
  logic [3:0] keymap_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int md[4];
  int mcnt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcnt = 0;
  endtask

  task automatic model_apply(input int code);
    if (code <= 9) begin
      for (int i = 3; i > 0; i--) md[i] = md[i-1];
      md[0] = code;
      if (mcnt < 4) mcnt++;
    end else if (code == 10) begin
      if (mcnt > 0) begin
        for (int i = 0; i < 3; i++) md[i] = md[i+1];
        md[3] = 0;
        mcnt--;
      end
    end else if (code == 12) begin
      model_reset();
    end
  endtask

  function automatic logic [31:0] model_digits();
    return 32'(md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0]);
  endfunction

  function automatic logic [3:0] rot_expect(input logic [3:0] r0);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (!r0[i]) p = i;
    return ~(4'b0001 << ((p + 1) % 4));
  endfunction

  task automatic tick_wait(input int n);
    repeat (n * ClkDiv) @(negedge clk);
  endtask

  task automatic wait_event(input int prev, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ev_cnt != prev) got = 1'b1;
    end
  endtask

  task automatic press_key(input int r, input int c, input string tag);
    int         prev;
    bit         got;
    logic [3:0] idx;
    idx = 4'(r * 4 + c);
    prev = ev_cnt;
    pressed = '0;
    pressed[idx] = 1'b1;
    wait_event(prev, got);
    check({tag, "_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      model_apply(int'(keymap_tbl[idx]));
      check({tag, "_code"}, {28'd0, ev_code[prev]}, {28'd0, keymap_tbl[idx]});
      check({tag, "_digits"}, {16'd0, bus.digits}, model_digits());
      check({tag, "_cnt"}, {29'd0, bus.digit_cnt}, 32'(mcnt));
    end
  endtask

  task automatic release_key();
    pressed = '0;
    tick_wait(6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r0;
    int         prev;
    bit         got;
    int         k, t0;

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_row", {28'd0, bus.row_out}, 32'hE);
    check("rst_digits", {16'd0, bus.digits}, 32'd0);
    check("rst_cnt", {29'd0, bus.digit_cnt}, 32'd0);
    check("rst_kv", {31'd0, bus.key_valid}, 32'd0);
    check("rst_code", {28'd0, bus.key_code}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      r0 = bus.row_out;
      repeat (ClkDiv) @(negedge clk);
      check("row_rot", {28'd0, bus.row_out}, {28'd0, rot_expect(r0)});
    end

    // Clean press of the 5 key, then hold without a second event.
    press_key(1, 1, "p5");
`ifndef KEYPAD_AUTOREPEAT_EN
    prev = ev_cnt;
    tick_wait(8);
    check("p5_no_repeat", 32'(ev_cnt), 32'(prev));
`endif
    release_key();

    press_key(0, 0, "d1"); release_key();
    press_key(0, 1, "d2"); release_key();
    press_key(0, 2, "d3"); release_key();
    press_key(1, 0, "d4"); release_key();
    press_key(1, 1, "d5"); release_key();
    check("full_digits", {16'd0, bus.digits}, 32'h2345);
    press_key(0, 3, "bksp"); release_key();
    check("bksp_digits", {16'd0, bus.digits}, 32'h0234);
    press_key(2, 3, "clr"); release_key();
    press_key(0, 3, "bksp_empty"); release_key();

    for (int i = 0; i < 10; i++) begin
      k = int'($urandom_range(15, 0));
      press_key(k / 4, k % 4, "rnd");
      release_key();
    end

    // Bounce: column low for a single sampling tick on row 1.
    got = 1'b0;
    for (int i = 0; i < 100 && bus.row_out == 4'b1101; i++) @(negedge clk);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.row_out == 4'b1101) got = 1'b1;
    end
    check("bounce_row_found", {31'd0, got}, 32'd1);
    prev = ev_cnt;
    ovr_en = 1'b1;
    ovr_val = 4'b1110;
    repeat (4) @(negedge clk);
    ovr_val = 4'hF;
    tick_wait(6);
    check("bounce_no_event", 32'(ev_cnt), 32'(prev));
    r0 = bus.row_out;
    repeat (ClkDiv) @(negedge clk);
    check("bounce_scan_rot", {28'd0, bus.row_out}, {28'd0, rot_expect(r0)});
    ovr_en = 1'b0;
    press_key(1, 0, "after_bounce");
`ifndef KEYPAD_AUTOREPEAT_EN
    tick_wait(8);
    check("after_bounce_once", 32'(ev_cnt), 32'(prev + 1));
`endif
    release_key();

    // Two columns on one row: ignored.
    prev = ev_cnt;
    pressed = '0;
    pressed[8] = 1'b1;
    pressed[10] = 1'b1;
    tick_wait(12);
    check("two_col_no_event", 32'(ev_cnt), 32'(prev));
    release_key();

    // Short release is not accepted, so re-pressing gives no new event.
    press_key(2, 1, "p8");
`ifndef KEYPAD_AUTOREPEAT_EN
    prev = ev_cnt;
    pressed = '0;
    repeat (2 * ClkDiv) @(negedge clk);
    pressed[9] = 1'b1;
    tick_wait(8);
    check("short_release", 32'(ev_cnt), 32'(prev));
`endif
    release_key();

`ifdef KEYPAD_AUTOREPEAT_EN
    press_key(2, 3, "ar_clr"); release_key();
    prev = ev_cnt;
    pressed = '0;
    pressed[8] = 1'b1;
    wait_event(prev, got);
    check("ar_seen", {31'd0, got}, 32'd1);
    t0 = got ? ev_cyc[prev] : 0;
    repeat (13 * ClkDiv) @(negedge clk);
    release_key();
    for (int i = 0; i < 3; i++) model_apply(7);
    check("ar_count", 32'(ev_cnt), 32'(prev + 3));
    if (ev_cnt >= prev + 3) begin
      check("ar_gap1", 32'(ev_cyc[prev+1] - t0), 32'(Rep * ClkDiv));
      check("ar_gap2", 32'(ev_cyc[prev+2] - t0), 32'(2 * Rep * ClkDiv));
    end
    check("ar_digits", {16'd0, bus.digits}, model_digits());
    check("ar_digits_const", {16'd0, bus.digits}, 32'h0777);
`endif

    // Reset in the middle of a debounce clears everything.
    check("pre_rst_digits", {16'd0, bus.digits}, model_digits());
    pressed = '0;
    pressed[0] = 1'b1;
    tick_wait(5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("mid_rst_row", {28'd0, bus.row_out}, 32'hE);
    check("mid_rst_digits", {16'd0, bus.digits}, model_digits());
    check("mid_rst_cnt", {29'd0, bus.digit_cnt}, 32'(mcnt));
    check("mid_rst_code", {28'd0, bus.key_code}, 32'd0);
    check("mid_rst_kv", {31'd0, bus.key_valid}, 32'd0);
    pressed = '0;
    rst = 1'b0;
    tick_wait(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
